// File: rtl/conv33_layer_seq.sv
// Layer sequencer for the 3x3 conv kernel: queues per-layer descriptors, loads them into the
// kernel cfg registers, starts the kernel, drains results and tracks sums, layers and timeouts.
module conv33_layer_seq #(
    parameter int COL          = 14,
    parameter int CHN_WIDTH    = 4,
    parameter int FMS_WIDTH    = 8,
    parameter int DESC_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 16,
    parameter int WDOG_WIDTH   = 20
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic                          abort,
    input  logic                          err_clr,
    input  logic                          desc_valid,
    output logic                          desc_ready,
    input  logic [CHN_WIDTH-1:0]          desc_ci,
    input  logic [CHN_WIDTH-1:0]          desc_co,
    input  logic                          desc_stride,
    input  logic                          desc_group,
    input  logic [FMS_WIDTH-1:0]          desc_ifm_size,
    output logic [CHN_WIDTH-1:0]          cfg_ci,
    output logic [CHN_WIDTH-1:0]          cfg_co,
    output logic                          cfg_stride,
    output logic                          cfg_group,
    output logic [FMS_WIDTH-1:0]          cfg_ifm_size,
    output logic                          start_conv,
    input  logic                          conv_done,
    input  logic [COL-1:0]                sum_valid,
    output logic                          busy,
    output logic                          layer_done,
    output logic [7:0]                    layer_cnt,
    output logic [23:0]                   sum_cnt,
    output logic [$clog2(DESC_DEPTH):0]   fifo_level,
    output logic                          err_timeout
);

    localparam int LW  = $clog2(DESC_DEPTH);
    localparam int DW  = 2 * CHN_WIDTH + 2 + FMS_WIDTH;
    localparam int DCW = $clog2(DRAIN_CYCLES) + 1;
    localparam int PW  = $clog2(COL + 1);
    localparam logic [LW:0]     FULL_LEVEL = (LW + 1)'(DESC_DEPTH);
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_START, S_RUN, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         mem_q [DESC_DEPTH];
    logic [LW-1:0]         wrPtr_q, rdPtr_q, headIdx;
    logic [LW:0]           level_q;
    logic [DW-1:0]         cfg_q, cfg_d;
    logic [23:0]           sumCnt_q, sumCnt_d;
    logic [7:0]            layerCnt_q, layerCnt_d;
    logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
    logic [DCW-1:0]        drainCnt_q, drainCnt_d;
    logic                  err_q, err_d;
    logic                  push, pop;
    logic [PW-1:0]         sumInc;
    logic [24:0]           sumAdd;

    assign desc_ready = (level_q != FULL_LEVEL);
    assign push       = desc_valid && desc_ready && !abort;
    assign pop        = (state_q == S_IDLE) && (state_d == S_LOAD);
    // The head was popped on the IDLE->LOAD edge, so LOAD reads the slot just behind rdPtr_q.
    assign headIdx    = rdPtr_q - LW'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (enable && (level_q != '0) && !err_q) state_d = S_LOAD;
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_START;
            S_START:  state_d = S_RUN;
            S_RUN: begin
                if (conv_done)          state_d = S_DRAIN;
                else if (wdog_q == '1)  state_d = S_ERR;
            end
            S_DRAIN:  if (drainCnt_q == DRAIN_LAST) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_comb begin
        sumInc = '0;
        for (int i = 0; i < COL; i++) sumInc = sumInc + PW'(sum_valid[i]);
        sumAdd = {1'b0, sumCnt_q} + 25'(sumInc);

        cfg_d      = cfg_q;
        sumCnt_d   = sumCnt_q;
        layerCnt_d = layerCnt_q;
        wdog_d     = wdog_q;
        drainCnt_d = (state_q == S_DRAIN) ? drainCnt_q + DCW'(1) : '0;
        err_d      = err_q;
        if (err_clr) err_d = 1'b0;
        if (state_q == S_ERR) err_d = 1'b1;

        // Counters and cfg freeze in an abort cycle; only the FSM and queue react.
        if (!abort) begin
            if (state_q == S_LOAD) begin
                cfg_d    = mem_q[headIdx];
                sumCnt_d = '0;
            end
            if (state_q inside {S_START, S_RUN, S_DRAIN, S_DONE})
                sumCnt_d = sumAdd[24] ? '1 : sumAdd[23:0];
            if (state_q == S_START) wdog_d = '0;
            if (state_q == S_RUN)   wdog_d = (sum_valid != '0) ? '0 : wdog_q + WDOG_WIDTH'(1);
            if (state_q == S_DONE)  layerCnt_d = layerCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            cfg_q      <= '0;
            sumCnt_q   <= '0;
            layerCnt_q <= '0;
            wdog_q     <= '0;
            drainCnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            sumCnt_q   <= sumCnt_d;
            layerCnt_q <= layerCnt_d;
            wdog_q     <= wdog_d;
            drainCnt_q <= drainCnt_d;
            err_q      <= err_d;
            if (abort) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                level_q <= '0;
            end else begin
                if (push) wrPtr_q <= wrPtr_q + LW'(1);
                if (pop)  rdPtr_q <= rdPtr_q + LW'(1);
                if (push && !pop)      level_q <= level_q + 1'b1;
                else if (pop && !push) level_q <= level_q - 1'b1;
            end
        end
    end

    // Descriptor storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= {desc_ci, desc_co, desc_stride, desc_group, desc_ifm_size};
    end

    assign {cfg_ci, cfg_co, cfg_stride, cfg_group, cfg_ifm_size} = cfg_q;
    assign start_conv  = (state_q == S_START);
    assign busy        = (state_q != S_IDLE);
    assign layer_done  = (state_q == S_DONE);
    assign layer_cnt   = layerCnt_q;
    assign sum_cnt     = sumCnt_q;
    assign fifo_level  = level_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_conv33_layer_seq.sv
// Directed self-checking bench for conv33_layer_seq: single layer, full queue, enable gating,
// watchdog timeout, abort and asynchronous reset, with hand-computed expectations.
module tb_conv33_layer_seq;

    localparam int WDOG = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable, abort, err_clr, desc_valid, desc_ready;
    logic [3:0]  desc_ci, desc_co, cfg_ci, cfg_co;
    logic        desc_stride, desc_group, cfg_stride, cfg_group;
    logic [7:0]  desc_ifm_size, cfg_ifm_size, layer_cnt;
    logic        start_conv, conv_done, busy, layer_done, err_timeout;
    logic [13:0] sum_valid;
    logic [23:0] sum_cnt;
    logic [2:0]  fifo_level;

    logic [17:0] descTab [10];
    int          checkCount = 0;
    int          passCount  = 0;
    int          cnt, extra, nStart, nDone;

    conv33_layer_seq #(
        .COL(14), .CHN_WIDTH(4), .FMS_WIDTH(8), .DESC_DEPTH(4),
        .DRAIN_CYCLES(16), .WDOG_WIDTH(WDOG)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .abort(abort), .err_clr(err_clr),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_ci(desc_ci), .desc_co(desc_co),
        .desc_stride(desc_stride), .desc_group(desc_group), .desc_ifm_size(desc_ifm_size),
        .cfg_ci(cfg_ci), .cfg_co(cfg_co), .cfg_stride(cfg_stride), .cfg_group(cfg_group),
        .cfg_ifm_size(cfg_ifm_size), .start_conv(start_conv), .conv_done(conv_done),
        .sum_valid(sum_valid), .busy(busy), .layer_done(layer_done), .layer_cnt(layer_cnt),
        .sum_cnt(sum_cnt), .fifo_level(fifo_level), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    function automatic logic [31:0] cfgWord();
        return {14'd0, cfg_ci, cfg_co, cfg_stride, cfg_group, cfg_ifm_size};
    endfunction

    // Holds one descriptor on the push interface for exactly one clock.
    task automatic applyStimulus(input logic [17:0] d);
        {desc_ci, desc_co, desc_stride, desc_group, desc_ifm_size} = d;
        desc_valid = 1'b1;
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    task automatic waitStart(output int n);
        n = 0;
        while (!start_conv && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("startSeen", {31'd0, start_conv}, 32'd1);
    endtask

    task automatic waitLayerDone(output int n);
        n = 0;
        while (!layer_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("layerDoneSeen", {31'd0, layer_done}, 32'd1);
    endtask

    // Kernel model, entered in the START cycle: sums for svCycles, conv_done at cycle doneAfter.
    task automatic runKernel(input int doneAfter, input int svCycles, output int starts);
        starts = 0;
        for (int k = 1; k <= doneAfter; k++) begin
            @(negedge clk);
            if (start_conv) starts++;
            sum_valid = (k <= svCycles) ? 14'h3fff : 14'h0;
            conv_done = (k == doneAfter);
        end
        @(negedge clk);
        sum_valid = '0;
        conv_done = 1'b0;
    endtask

    task automatic idleWatch(input int cycles, output int starts, output int dones);
        starts = 0;
        dones  = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (start_conv) starts++;
            if (layer_done) dones++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, expected end before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        descTab[0] = {4'd2,  4'd2,  1'b0, 1'b0, 8'd8};
        descTab[1] = {4'd1,  4'd3,  1'b0, 1'b0, 8'd10};
        descTab[2] = {4'd4,  4'd5,  1'b1, 1'b0, 8'd20};
        descTab[3] = {4'd7,  4'd2,  1'b0, 1'b1, 8'd33};
        descTab[4] = {4'd15, 4'd15, 1'b1, 1'b1, 8'd255};
        descTab[5] = {4'd9,  4'd9,  1'b0, 1'b0, 8'd9};
        descTab[6] = {4'd3,  4'd1,  1'b1, 1'b0, 8'd64};
        descTab[7] = {4'd5,  4'd6,  1'b0, 1'b1, 8'd16};
        descTab[8] = {4'd11, 4'd12, 1'b1, 1'b1, 8'd100};
        descTab[9] = {4'd6,  4'd4,  1'b0, 1'b0, 8'd12};

        rstn = 1'b0; enable = 1'b0; abort = 1'b0; err_clr = 1'b0; desc_valid = 1'b0;
        desc_ci = '0; desc_co = '0; desc_stride = 1'b0; desc_group = 1'b0; desc_ifm_size = '0;
        conv_done = 1'b0; sum_valid = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstReady", {31'd0, desc_ready}, 32'd1);
        checkOutput("rstLevel", {29'd0, fifo_level}, 32'd0);
        checkOutput("rstCfg", cfgWord(), 32'd0);
        checkOutput("rstStart", {31'd0, start_conv}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single layer: start 4 cycles after the push cycle, 10x14 sums, drain then done.
        enable = 1'b1;
        applyStimulus(descTab[0]);
        waitStart(cnt);
        checkOutput("t1StartLatency", cnt, 32'd3);
        checkOutput("t1CfgAtStart", cfgWord(), {14'd0, descTab[0]});
        runKernel(100, 10, extra);
        checkOutput("t1SinglePulse", extra, 32'd0);
        checkOutput("t1CfgInDrain", cfgWord(), {14'd0, descTab[0]});
        waitLayerDone(cnt);
        checkOutput("t1DrainLen", cnt, 32'd16);
        @(negedge clk);
        checkOutput("t1LayerDonePulse", {31'd0, layer_done}, 32'd0);
        checkOutput("t1LayerCnt", layer_cnt, 32'd1);
        checkOutput("t1SumCnt", sum_cnt, 32'd140);
        checkOutput("t1Idle", {31'd0, busy}, 32'd0);

        // Queue full: 4 accepted, 5th dropped, then run all four in order.
        enable = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) checkOutput("t2ReadyFull", {31'd0, desc_ready}, 32'd0);
            applyStimulus(descTab[i]);
        end
        checkOutput("t2Level", {29'd0, fifo_level}, 32'd4);
        checkOutput("t2NoStartWhileDisabled", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            waitStart(cnt);
            checkOutput($sformatf("t2Cfg%0d", i), cfgWord(), {14'd0, descTab[i]});
            runKernel(30, 2, extra);
            waitLayerDone(cnt);
            @(negedge clk);
            checkOutput($sformatf("t2Sum%0d", i), sum_cnt, 32'd28);
        end
        checkOutput("t2LayerCnt", layer_cnt, 32'd5);
        idleWatch(10, nStart, nDone);
        checkOutput("t2DroppedNoStart", nStart, 32'd0);
        checkOutput("t2LevelEmpty", {29'd0, fifo_level}, 32'd0);

        // Enable gating: one push overlaps the pop, leaving two queued behind layer A.
        for (int i = 6; i <= 8; i++) applyStimulus(descTab[i]);
        waitStart(cnt);
        enable = 1'b0;
        checkOutput("t3LevelTwo", {29'd0, fifo_level}, 32'd2);
        runKernel(40, 3, extra);
        waitLayerDone(cnt);
        @(negedge clk);
        idleWatch(20, nStart, nDone);
        checkOutput("t3NoStart", nStart, 32'd0);
        checkOutput("t3Level", {29'd0, fifo_level}, 32'd2);
        checkOutput("t3LayerCnt", layer_cnt, 32'd6);
        checkOutput("t3CfgHeld", cfgWord(), {14'd0, descTab[6]});
        checkOutput("t3Sum", sum_cnt, 32'd42);

        // Watchdog: silent kernel, error 2^W+2 cycles after the START cycle.
        enable = 1'b1;
        waitStart(cnt);
        checkOutput("t4Cfg", cfgWord(), {14'd0, descTab[7]});
        cnt = 0;
        while (!err_timeout && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("t4WdogCycles", cnt, (32'd1 << WDOG) + 32'd2);
        checkOutput("t4IdleAfterErr", {31'd0, busy}, 32'd0);
        checkOutput("t4LevelHeld", {29'd0, fifo_level}, 32'd1);
        idleWatch(10, nStart, nDone);
        checkOutput("t4Blocked", nStart, 32'd0);
        checkOutput("t4ErrSticky", {31'd0, err_timeout}, 32'd1);
        checkOutput("t4LayerCntHeld", layer_cnt, 32'd6);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("t4ErrCleared", {31'd0, err_timeout}, 32'd0);
        waitStart(cnt);
        checkOutput("t4ResumeCfg", cfgWord(), {14'd0, descTab[8]});
        runKernel(20, 1, extra);
        waitLayerDone(cnt);
        @(negedge clk);
        checkOutput("t4LayerCnt", layer_cnt, 32'd7);

        // Abort in RUN with three queued; a push in the abort cycle and a late done are ignored.
        for (int i = 1; i <= 4; i++) applyStimulus(descTab[i]);
        waitStart(cnt);
        repeat (3) @(negedge clk);
        checkOutput("t5LevelThree", {29'd0, fifo_level}, 32'd3);
        abort = 1'b1;
        {desc_ci, desc_co, desc_stride, desc_group, desc_ifm_size} = descTab[9];
        desc_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        desc_valid = 1'b0;
        checkOutput("t5Busy", {31'd0, busy}, 32'd0);
        checkOutput("t5Level", {29'd0, fifo_level}, 32'd0);
        checkOutput("t5CfgKept", cfgWord(), {14'd0, descTab[1]});
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        idleWatch(25, nStart, nDone);
        checkOutput("t5NoLayerDone", nDone, 32'd0);
        checkOutput("t5NoStart", nStart, 32'd0);
        checkOutput("t5LayerCnt", layer_cnt, 32'd7);

        // Asynchronous reset mid-RUN clears outputs without waiting for a clock edge.
        applyStimulus(descTab[2]);
        waitStart(cnt);
        repeat (5) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checkOutput("t6Busy", {31'd0, busy}, 32'd0);
        checkOutput("t6LayerCnt", layer_cnt, 32'd0);
        checkOutput("t6SumCnt", sum_cnt, 32'd0);
        checkOutput("t6Cfg", cfgWord(), 32'd0);
        checkOutput("t6Ready", {31'd0, desc_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("t6LevelAfter", {29'd0, fifo_level}, 32'd0);
        checkOutput("t6IdleAfter", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
